mod_stream_accumulator: RTL and testbench
=========================================

Name: mod_stream_accumulator

Overview:
- Sequential front/back stage wrapped around the modulo (2^N - K) parallel-prefix adder.
- Accepts a stream of N-bit operands over a valid/ready handshake and folds them into a running residue modulo M = 2^N - K, one operand per cycle.
- Presents the frame result on a valid/ready output port.
- One adder instance sits in the loop: A = accumulator register, B = range-corrected incoming operand, k = latched K.

Parameters:
- N, 7, operand/residue width; modulus M = 2^N - K.
- CNT_W, 8, width of the operand counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- k  in  N  modulus offset K; sampled on the first accepted beat of each frame.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  N  operand.
- in_last  in  1  marks the final operand of a frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  N  frame sum mod M.
- out_count  out  CNT_W  operands in frame, saturating at 2^CNT_W - 1.
- out_range_err  out  1  at least one operand in the frame was >= M.
- out_cfg_err  out  1  sampled K was illegal.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, accumulator 0, count 0, k_reg 0, all error flags 0, in_ready 0 while rst_n=0 and 1 after release, out_valid 0, out_sum 0, out_count 0.
- Transfer rule: a beat transfers when valid & ready are both high at a rising edge.

State IDLE:
- in_ready=1, out_valid=0.
- On an accepted beat: k_reg <= k; cfg_err <= (k==0) | (k >= 2^(N-1)); acc <= corr(in_data); count <= 1.
- Next state is DONE if in_last=1, else ACC.

State ACC:
- in_ready=1.
- On an accepted beat: acc <= (acc + corr(in_data)) mod M, using k_reg; count <= count + 1, saturating.
- in_last=1 -> DONE.
- No beat: hold all state; bubbles are allowed indefinitely.

State DONE:
- in_ready=0, out_valid=1.
- out_sum, out_count, out_range_err and out_cfg_err are registered and stable while out_valid=1 & out_ready=0.
- When out_ready=1: next state IDLE, out_valid drops next cycle, and acc, count and flags clear.
- One bubble cycle is required between frames; no input is accepted in DONE even if out_ready=1.

Arithmetic:
- corr(x) = (x >= M) ? x - M : x. Because K < 2^(N-1), a single subtraction suffices.
- If x >= M, range_err is set sticky for the frame.
- The modular add matches the adder stage: sum = A+B; if A+B >= M, result = A+B-M. Both inputs are always < M. Result width is N with no carry out.

Latency:
- Result is visible the cycle after the in_last beat is accepted.
- A single-beat frame (in_last on the first beat) goes IDLE -> DONE directly.

Error cases:
- cfg_err=1: arithmetic still runs with k_reg, but out_sum is forced to 0 in DONE.
- k changing mid-frame is ignored; only the first-beat sample is used.

Reset mid-frame: async clear to IDLE; the partial frame is discarded and no out_valid is produced.

Test Plan:
- N=7, k=3 (M=125), frame {100, 50, 30 last}, out_ready=1 -> out_valid one cycle after beat 3; out_sum=55, out_count=3, both err flags 0.
- Single beat {124 last} -> IDLE->DONE; out_sum=124, out_count=1; in_ready=0 during DONE and 1 again 2 cycles later.
- Frame {127, 0 last}, k=3 -> operand corrected to 2; out_sum=2, out_range_err=1; next frame {5 last} -> out_range_err=0.
- Frame {124, 3 idle cycles, 124 last}, out_ready held low for 5 cycles -> out_sum=123, held stable with out_valid=1 for all 5 cycles; in_valid asserted during DONE is not accepted.
- k=0, frame {10 last} -> out_cfg_err=1, out_sum=0; k=64 gives the same flag.
- Assert rst_n low asynchronously after 2 beats of {60, 70, ...} -> out_valid=0 and in_ready=0 during reset; after release, frame {1 last} -> out_sum=1, out_count=1.

Source files
------------

// File: rtl/mod_stream_accumulator.sv
// Streaming accumulator: folds valid/ready operands into a running residue
// modulo M = 2^N - K and presents each frame result on a valid/ready port.
module mod_stream_accumulator #(
  parameter int N     = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     k,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_range_err,
  output logic             out_cfg_err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     k_q, k_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             range_err_q, range_err_d;
  logic             cfg_err_q, cfg_err_d;

  logic             beat;
  logic [N-1:0]     k_eff;
  logic [N:0]       mod_m;
  logic             b_over;
  logic [N-1:0]     b_corr;
  logic [N-1:0]     a_op;
  logic [N:0]       raw_sum;
  logic [N-1:0]     mod_sum;

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign in_ready = rst_n & (state_q != DONE);
  assign beat     = in_valid & in_ready;

  // Single modular adder in the loop. The first beat of a frame uses the live
  // k (it is being latched this cycle) and a zero accumulator operand.
  always_comb begin
    k_eff   = (state_q == IDLE) ? k : k_q;
    mod_m   = {1'b1, {N{1'b0}}} - {1'b0, k_eff};
    b_over  = ({1'b0, in_data} >= mod_m);
    b_corr  = b_over ? N'({1'b0, in_data} - mod_m) : in_data;
    a_op    = (state_q == IDLE) ? '0 : acc_q;
    raw_sum = {1'b0, a_op} + {1'b0, b_corr};
    mod_sum = (raw_sum >= mod_m) ? N'(raw_sum - mod_m) : raw_sum[N-1:0];
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    count_d     = count_q;
    range_err_d = range_err_q;
    cfg_err_d   = cfg_err_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          k_d         = k;
          cfg_err_d   = (k == '0) | k[N-1];
          acc_d       = mod_sum;
          count_d     = CNT_W'(1);
          range_err_d = b_over;
          state_d     = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d       = mod_sum;
          count_d     = (&count_q) ? count_q : count_q + CNT_W'(1);
          range_err_d = range_err_q | b_over;
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          count_d     = '0;
          range_err_d = 1'b0;
          cfg_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      count_q     <= '0;
      range_err_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      count_q     <= count_d;
      range_err_q <= range_err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Result fields are registers muxed onto the port only while presenting.
  assign out_valid     = (state_q == DONE);
  assign out_sum       = (out_valid && !cfg_err_q) ? acc_q : '0;
  assign out_count     = out_valid ? count_q : '0;
  assign out_range_err = out_valid & range_err_q;
  assign out_cfg_err   = out_valid & cfg_err_q;

endmodule

// File: tb/tb_mod_stream_accumulator.sv
// Directed bench for mod_stream_accumulator with hand-computed results.
module tb_mod_stream_accumulator;

  localparam int N     = 7;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     k;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_range_err;
  logic             out_cfg_err;

  int checks_total  = 0;
  int checks_passed = 0;

  mod_stream_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .k             (k),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_count     (out_count),
    .out_range_err (out_range_err),
    .out_cfg_err   (out_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Present one operand and return 1 time unit after the edge that took it.
  task automatic beat(input logic [N-1:0] d, input logic last, input logic [N-1:0] kk);
    int waited = 0;
    in_data  = d;
    in_last  = last;
    k        = kk;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("beat_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [N-1:0] sum,
                               input logic [CNT_W-1:0] cnt, input logic rerr,
                               input logic cerr);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(sum));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_rerr"},  32'(out_range_err), 32'(rerr));
    check({tag, "_cerr"},  32'(out_cfg_err),   32'(cerr));
  endtask

  initial begin
    rst_n     = 1'b0;
    k         = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #2;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    #21 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 100+50+30 mod 125 = 55
    beat(7'd100, 1'b0, 7'd3);
    beat(7'd50,  1'b0, 7'd3);
    beat(7'd30,  1'b1, 7'd3);
    expect_result("f1", 7'd55, 8'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("f1_valid_drop", 32'(out_valid), 32'd0);

    // Single beat goes straight to DONE.
    beat(7'd124, 1'b1, 7'd3);
    expect_result("f2", 7'd124, 8'd1, 1'b0, 1'b0);
    check("f2_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("f2_ready_again", 32'(in_ready), 32'd1);

    // 127 >= 125 is corrected to 2 and flags a range error.
    beat(7'd127, 1'b0, 7'd3);
    beat(7'd0,   1'b1, 7'd3);
    expect_result("f3", 7'd2, 8'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    beat(7'd5, 1'b1, 7'd3);
    expect_result("f4", 7'd5, 8'd1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Bubbles mid-frame, backpressure for 5 cycles, input offered during DONE.
    out_ready = 1'b0;
    beat(7'd124, 1'b0, 7'd3);
    repeat (3) @(posedge clk);
    #1;
    beat(7'd124, 1'b1, 7'd3);
    in_data  = 7'd7;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("f5_hold_valid", 32'(out_valid), 32'd1);
      check("f5_hold_sum",   32'(out_sum),   32'd123);
      check("f5_hold_count", 32'(out_count), 32'd2);
      check("f5_hold_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("f5_valid_drop", 32'(out_valid), 32'd0);
    beat(7'd5, 1'b1, 7'd3);
    expect_result("f6", 7'd5, 8'd1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Illegal K values: result forced to zero.
    beat(7'd10, 1'b1, 7'd0);
    expect_result("k0", 7'd0, 8'd1, 1'b0, 1'b1);
    @(posedge clk); #1;
    beat(7'd10, 1'b1, 7'd64);
    expect_result("k64", 7'd0, 8'd1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // K change mid-frame is ignored: 100+50 mod 125 = 25 (not mod 118).
    beat(7'd100, 1'b0, 7'd3);
    beat(7'd50,  1'b1, 7'd10);
    expect_result("kchg", 7'd25, 8'd1 + 8'd1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // 260 ones: 260 mod 125 = 10, count saturates at 255.
    for (int i = 0; i < 260; i++) beat(7'd1, (i == 259), 7'd3);
    expect_result("sat", 7'd10, 8'd255, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame discards the partial frame.
    beat(7'd60, 1'b0, 7'd3);
    beat(7'd70, 1'b0, 7'd3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    beat(7'd1, 1'b1, 7'd3);
    expect_result("after_rst", 7'd1, 8'd1, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
